// File: rtl/encode_pkg.sv
// Shared types and helpers for the 8-to-3 request encoder/arbiter.
// Default widths, the presenter state encoding and a highest-set-bit helper.
package encode_pkg;

    localparam int N_IN_DEF   = 8;
    localparam int CODE_W_DEF = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Scans upward so the last hit, the highest set index, is kept.
    function automatic logic [CODE_W_DEF-1:0] hi_index(input logic [N_IN_DEF-1:0] v);
        hi_index = '0;
        for (int i = 0; i < N_IN_DEF; i++) begin
            if (v[i]) begin
                hi_index = i[CODE_W_DEF-1:0];
            end
        end
    endfunction

endpackage

// File: rtl/prio_enc83.sv
// Combinational 8-to-3 priority encoder; the highest set input wins.
// any flags a non-zero input vector so code can be qualified.
module prio_enc83
    import encode_pkg::*;
(
    input  logic [7:0] in,
    output logic [2:0] code,
    output logic       any
);

    assign code = hi_index(in);
    assign any  = |in;

endmodule

// File: rtl/encode83_arb.sv
// Registered 8-to-3 request encoder: captures requests into a pending set and
// presents the highest pending index with a valid/ack handshake.
//
// state   | meaning
// IDLE    | valid low; waits for enable and a non-empty pending set
// PRESENT | valid high; code held stable until ack clears that request
module encode83_arb
    import encode_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int CODE_W = CODE_W_DEF,
    parameter int EDGE   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_IN-1:0]   req,
    input  logic              ack,
    input  logic              clr_ovr,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              any,
    output logic [N_IN-1:0]   ovr
);

    logic [N_IN-1:0]   r_pending;
    logic [N_IN-1:0]   r_req_d;
    logic [N_IN-1:0]   r_ovr;
    logic [CODE_W-1:0] r_code;
    logic              r_valid;
    state_t            r_state;

    logic [N_IN-1:0]   w_cap;
    logic [N_IN-1:0]   w_clr_mask;
    logic [N_IN-1:0]   w_ovr_set;
    logic [2:0]        w_hi_code;
    logic              w_any;

    always_comb begin
        if (EDGE != 0) begin
            w_cap = req & ~r_req_d & {N_IN{en}};
        end else begin
            w_cap = req & {N_IN{en}};
        end
    end

    always_comb begin
        w_clr_mask = '0;
        if (r_state == PRESENT && ack) begin
            w_clr_mask[r_code] = 1'b1;
        end
    end

    // A bit being acked this cycle is consumed, so re-capturing it is not an overrun.
    assign w_ovr_set = w_cap & r_pending & ~w_clr_mask;

    prio_enc83 u_prio (
        .in   (r_pending),
        .code (w_hi_code),
        .any  (w_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_req_d   <= '0;
            r_ovr     <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_state   <= IDLE;
        end else begin
            r_req_d   <= req;
            r_pending <= (r_pending & ~w_clr_mask) | w_cap;
            r_ovr     <= (clr_ovr ? '0 : r_ovr) | w_ovr_set;
            case (r_state)
                IDLE: begin
                    if (en && w_any) begin
                        r_code  <= w_hi_code;
                        r_valid <= 1'b1;
                        r_state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign code  = r_code;
    assign valid = r_valid;
    assign any   = w_any;
    assign ovr   = r_ovr;

endmodule
